i2c_slave: RTL

- I2C responder (target) for the existing i2c_master: the other end of the same two-wire bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address; receives write bytes or supplies read bytes, driving SDA open-drain.
- No clock stretching; SCL is input-only.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_bus_sync.sv | 49 ++++
 rtl/i2c_slave.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and acknowledge bit levels.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    RX_DATA   = 3'd3,
    RX_ACK    = 3'd4,
    TX_DATA   = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with a history flop; decodes clock edges and
// START/STOP conditions from one common synchronized pipeline.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_in
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_pipe[SYNC_STAGES-1];
  assign sda_now = sda_pipe[SYNC_STAGES-1];

  // Shift both lines through the synchronizer chain; idle bus level is 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
      scl_hist <= scl_now;
      sda_hist <= sda_now;
    end
  end

  assign scl_rise  = scl_now & ~scl_hist;
  assign scl_fall  = ~scl_now & scl_hist;
  // SDA may only move while SCL is stable high for a bus condition.
  assign start_det = scl_now & scl_hist & sda_hist & ~sda_now;
  assign stop_det  = scl_now & scl_hist & ~sda_hist & sda_now;
  assign sda_in    = sda_now;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, write reception, read transmission.
// SDA is only ever pulled low; SCL is never stretched.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h55,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw_mode,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_in;

  i2c_state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic       sda_low_reg, sda_low_next;
  logic [7:0] rx_data_next;
  logic       rx_valid_next, tx_req_next, rw_next, busy_next;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_in    (sda_in)
  );

  // Open-drain output: the register clears asynchronously, so reset frees the bus at once.
  assign sda = sda_low_reg ? 1'b0 : 1'bz;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      shift_reg   <= 8'h00;
      sda_low_reg <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      rw_mode     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      sda_low_reg <= sda_low_next;
      rx_data     <= rx_data_next;
      rx_valid    <= rx_valid_next;
      tx_req      <= tx_req_next;
      rw_mode     <= rw_next;
      busy        <= busy_next;
    end
  end

  // Next-state logic; bus conditions override whatever the FSM is doing.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shift_next    = shift_reg;
    sda_low_next  = sda_low_reg;
    rx_data_next  = rx_data;
    rx_valid_next = 1'b0;
    tx_req_next   = 1'b0;
    rw_next       = rw_mode;
    busy_next     = busy;

    if (stop_det) begin
      state_next   = IDLE;
      sda_low_next = 1'b0;
      busy_next    = 1'b0;
    end else if (start_det) begin
      state_next   = ADDR;
      cnt_next     = 4'd0;
      sda_low_next = 1'b0;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shift_next = {shift_reg[6:0], sda_in};
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              cnt_next = 4'd0;
              // shift_reg[6:0] holds the address; sda_in is the R/W bit.
              if (shift_reg[6:0] == SLAVE_ADDR) begin
                rw_next    = sda_in;
                busy_next  = 1'b1;
                state_next = ADDR_ACK;
              end else begin
                busy_next  = 1'b0;
                state_next = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          // First fall starts the ACK; second fall ends the 9th clock.
          if (scl_fall) begin
            if (!sda_low_reg) begin
              sda_low_next = 1'b1;
            end else if (!rw_mode) begin
              sda_low_next = 1'b0;
              cnt_next     = 4'd0;
              state_next   = RX_DATA;
            end else begin
              tx_req_next  = 1'b1;
              shift_next   = tx_data;
              sda_low_next = ~tx_data[7];
              cnt_next     = 4'd0;
              state_next   = TX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (scl_rise) begin
            shift_next = {shift_reg[6:0], sda_in};
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              rx_data_next  = {shift_reg[6:0], sda_in};
              rx_valid_next = 1'b1;
            end
          end else if (scl_fall && cnt_reg == 4'd8) begin
            sda_low_next = 1'b1;
            state_next   = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_low_next = 1'b0;
            cnt_next     = 4'd0;
            state_next   = RX_DATA;
          end
        end
        TX_DATA: begin
          // Bit 7 went out on entry; each fall presents the next bit.
          if (scl_fall) begin
            if (cnt_reg == 4'd7) begin
              sda_low_next = 1'b0;
              cnt_next     = 4'd0;
              state_next   = TX_ACK;
            end else begin
              shift_next   = {shift_reg[6:0], 1'b0};
              sda_low_next = ~shift_reg[6];
              cnt_next     = cnt_reg + 4'd1;
            end
          end
        end
        TX_ACK: begin
          // cnt_reg == 1 marks an ACK seen on this 9th clock.
          if (scl_rise) begin
            if (sda_in == ACK) begin
              cnt_next = 4'd1;
            end else begin
              busy_next  = 1'b0;
              state_next = WAIT_STOP;
            end
          end else if (scl_fall && cnt_reg == 4'd1) begin
            tx_req_next  = 1'b1;
            shift_next   = tx_data;
            sda_low_next = ~tx_data[7];
            cnt_next     = 4'd0;
            state_next   = TX_DATA;
          end
        end
        default: begin
          sda_low_next = 1'b0;
        end
      endcase
    end
  end

endmodule
